keypad_emulator: RTL and testbench

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_emulator_if.sv | 11 +
 rtl/keypad_emulator.sv | 151 +++++++++++++++
 tb/tb_keypad_emulator.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_emulator_if.sv
// Press-command channel between a host (master) and the keypad emulator (slave).
interface keypad_emulator_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_key;
    logic [7:0] cmd_hold;
    logic       cmd_err;

    modport master (output cmd_valid, cmd_key, cmd_hold, input cmd_ready, cmd_err);
    modport slave  (input cmd_valid, cmd_key, cmd_hold, output cmd_ready, cmd_err);
endinterface

// File: rtl/keypad_emulator.sv
// 3x3 keypad matrix emulator: plays one timed key press per command onto the row lines.
// Define KEYPAD_EMULATOR_BOUNCE_EN to generate LFSR contact chatter at press and release.
module keypad_emulator #(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned BOUNCE_TICKS = 4,
    parameter int unsigned GAP_TICKS    = 2
) (
    input  logic             clk,
    input  logic             reset,
    keypad_emulator_if.slave cmd,
    input  logic [2:0]       column,
    output logic [2:0]       row,
    output logic             busy,
    output logic             press_done
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {S_IDLE, S_BOUNCE_IN, S_HOLD, S_BOUNCE_OUT, S_GAP} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc;
    logic          tick;
    logic [7:0]    tcnt, tcnt_n, hold_cnt, hold_n, dur;
    logic [3:0]    key, key_n;
    logic          skip, skip_n;
    logic          accept, bad_key, done_n, contact;
    logic [1:0]    key_r, key_c;
    logic [2:0]    row_n;

    // Free-running press-timing prescaler
    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) presc <= '0;
        else        presc <= tick ? '0 : presc + PW'(1);
    end

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    logic [15:0] lfsr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    lfsr <= 16'hACE1;
        else if (tick) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
`endif

    assign accept  = cmd.cmd_valid && cmd.cmd_ready;
    assign bad_key = (cmd.cmd_key > 4'd8);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            tcnt          <= 8'd0;
            hold_cnt      <= 8'd1;
            key           <= 4'd0;
            skip          <= 1'b0;
            row           <= 3'b111;
            busy          <= 1'b0;
            press_done    <= 1'b0;
            cmd.cmd_ready <= 1'b0;
            cmd.cmd_err   <= 1'b0;
        end else begin
            state         <= state_n;
            tcnt          <= tcnt_n;
            hold_cnt      <= hold_n;
            key           <= key_n;
            skip          <= skip_n;
            row           <= row_n;
            busy          <= (state_n != S_IDLE);
            press_done    <= done_n;
            cmd.cmd_ready <= (state_n == S_IDLE);
            cmd.cmd_err   <= accept && bad_key;
        end
    end

    // Next state; a press accepted off a tick boundary discards its first partial tick
    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        hold_n  = hold_cnt;
        key_n   = key;
        skip_n  = skip;
        done_n  = 1'b0;
        dur     = 8'd1;
        case (state)
            S_BOUNCE_IN, S_BOUNCE_OUT: dur = 8'(BOUNCE_TICKS);
            S_HOLD:                    dur = hold_cnt;
            S_GAP:                     dur = 8'(GAP_TICKS);
            default:                   dur = 8'd1;
        endcase
        if (state == S_IDLE) begin
            if (accept && !bad_key) begin
                state_n = S_BOUNCE_IN;
                key_n   = cmd.cmd_key;
                hold_n  = (cmd.cmd_hold == 8'd0) ? 8'd1 : cmd.cmd_hold;
                tcnt_n  = 8'd0;
                skip_n  = !tick;
            end
        end else if (tick) begin
            if (skip) begin
                skip_n = 1'b0;
            end else if (tcnt == dur - 8'd1) begin
                tcnt_n = 8'd0;
                case (state)
                    S_BOUNCE_IN:  state_n = S_HOLD;
                    S_HOLD:       state_n = S_BOUNCE_OUT;
                    S_BOUNCE_OUT: state_n = S_GAP;
                    default:      state_n = S_IDLE;
                endcase
                done_n = (state == S_GAP);
            end else begin
                tcnt_n = tcnt + 8'd1;
            end
        end
    end

    // Latched key to matrix coordinates
    always_comb begin
        key_r = 2'd0;
        key_c = 2'd0;
        if (key >= 4'd6) begin
            key_r = 2'd2;
            key_c = 2'(key - 4'd6);
        end else if (key >= 4'd3) begin
            key_r = 2'd1;
            key_c = 2'(key - 4'd3);
        end else begin
            key_c = key[1:0];
        end
    end

    always_comb begin
        contact = 1'b0;
        case (state)
            S_HOLD:       contact = 1'b1;
`ifdef KEYPAD_EMULATOR_BOUNCE_EN
            S_BOUNCE_IN:  contact = lfsr[0];
            S_BOUNCE_OUT: contact = lfsr[0];
`else
            S_BOUNCE_IN:  contact = 1'b0;
            S_BOUNCE_OUT: contact = 1'b1;
`endif
            default:      contact = 1'b0;
        endcase
    end

    always_comb begin
        row_n = 3'b111;
        if (contact && !column[key_c]) row_n[key_r] = 1'b0;
    end
endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: vector table of single presses plus multi-cycle sequences.
module tb_keypad_emulator;
    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] column;
    logic [2:0] row;
    logic       busy;
    logic       press_done;

    keypad_emulator_if kif();

    keypad_emulator #(.TICK_DIV(4), .BOUNCE_TICKS(4), .GAP_TICKS(2)) dut (
        .clk(clk), .reset(reset), .cmd(kif), .column(column),
        .row(row), .busy(busy), .press_done(press_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0] key;
        logic [7:0] hold;
        logic [2:0] col;
        logic       exp_err;
        logic [2:0] exp_row;
        int         ticks;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
    // Reference prescaler (TICK_DIV = 4) and chatter LFSR
    logic [1:0]  m_cnt;
    logic [15:0] m_lfsr, m_lfsr_d1;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt     <= 2'd0;
            m_lfsr    <= 16'hACE1;
            m_lfsr_d1 <= 16'hACE1;
        end else begin
            m_lfsr_d1 <= m_lfsr;
            m_cnt     <= m_cnt + 2'd1;
            if (m_cnt == 2'd3)
                m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end
`endif

    // Issue one command from the table and observe it until press_done or a cycle budget
    task automatic run_vec(input int i);
        vec_t       v;
        int         cyc, errs, dones, busy_seen;
        logic [2:0] row_and;
        v = vecs[i];
        @(negedge clk);
        column         = v.col;
        kif.cmd_key    = v.key;
        kif.cmd_hold   = v.hold;
        kif.cmd_valid  = 1'b1;
        check($sformatf("v%0d_ready", i), int'(kif.cmd_ready), 1);
        @(negedge clk);
        kif.cmd_valid = 1'b0;
        cyc = 1; errs = int'(kif.cmd_err); dones = int'(press_done);
        busy_seen = int'(busy); row_and = row;
        while (!press_done && cyc < (v.exp_err ? 10 : 300)) begin
            @(negedge clk);
            cyc++;
            row_and   &= row;
            errs      += int'(kif.cmd_err);
            dones     += int'(press_done);
            busy_seen |= int'(busy);
        end
        check($sformatf("v%0d_err", i), errs, int'(v.exp_err));
        check($sformatf("v%0d_row", i), int'(row_and), int'(v.exp_row));
        if (v.exp_err) begin
            check($sformatf("v%0d_busy", i), busy_seen, 0);
            check($sformatf("v%0d_done", i), dones, 0);
        end else begin
            check($sformatf("v%0d_done", i), dones, 1);
            check_range($sformatf("v%0d_dur", i), cyc - 1, 4 * v.ticks, 4 * v.ticks + 4);
            check($sformatf("v%0d_row_open_at_done", i), int'(row), 7);
        end
    endtask

    initial begin
        logic [2:0] cols[3];
        int cyc, bad, low, early, last_low, viol, dones;
        cols[0] = 3'b110; cols[1] = 3'b101; cols[2] = 3'b011;

        vecs[0] = '{4'd4, 8'd3, 3'b101, 1'b0, 3'b101, 13};
        vecs[1] = '{4'd0, 8'd1, 3'b110, 1'b0, 3'b110, 11};
        vecs[2] = '{4'd8, 8'd0, 3'b011, 1'b0, 3'b011, 11};
        vecs[3] = '{4'd5, 8'd2, 3'b011, 1'b0, 3'b101, 12};
        vecs[4] = '{4'd7, 8'd2, 3'b110, 1'b0, 3'b111, 12};
        vecs[5] = '{4'd9, 8'd5, 3'b110, 1'b1, 3'b111, 0};
        vecs[6] = '{4'd15, 8'd5, 3'b011, 1'b1, 3'b111, 0};
        vecs[7] = '{4'd3, 8'd5, 3'b110, 1'b0, 3'b101, 15};

        reset = 1'b0; column = 3'b111;
        kif.cmd_valid = 1'b0; kif.cmd_key = 4'd0; kif.cmd_hold = 8'd0;
        repeat (3) @(negedge clk);
        check("rst_row", int'(row), 7);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(press_done), 0);
        check("rst_err", int'(kif.cmd_err), 0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_ready_after_release", int'(kif.cmd_ready), 1);

        for (int i = 0; i < 8; i++) run_vec(i);

        // Key 4 with the scanner cycling its column strobe
        @(negedge clk);
        kif.cmd_key = 4'd4; kif.cmd_hold = 8'd3; kif.cmd_valid = 1'b1; column = 3'b110;
        @(negedge clk);
        kif.cmd_valid = 1'b0;
        cyc = 0; bad = 0; low = 0; early = 0; last_low = 0;
        do begin
            column = cols[cyc % 3];
            @(negedge clk);
            cyc++;
            if (row != 3'b111 && !(row == 3'b101 && column == 3'b101)) bad++;
            if (row == 3'b101) begin
                low++;
                last_low = cyc;
            end
            if (cyc <= 16 && row != 3'b111) early++;
        end while (!press_done && cyc < 300);
        check("scan_row_only_on_col1", bad, 0);
        check("scan_done_seen", int'(press_done), 1);
`ifndef KEYPAD_EMULATOR_BOUNCE_EN
        check("scan_open_in_bounce_in", early, 0);
        check_range("scan_low_cycles", low, 9, 10);
        check_range("scan_open_in_gap", cyc - last_low, 8, 300);
`endif

        // Reset dropped in the middle of HOLD
        @(negedge clk);
        column = 3'b110; kif.cmd_key = 4'd0; kif.cmd_hold = 8'd10; kif.cmd_valid = 1'b1;
        @(negedge clk);
        kif.cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        check("mid_hold_row", int'(row), 6);
        check("mid_hold_busy", int'(busy), 1);
        reset = 1'b0;
        #1;
        check("abort_row", int'(row), 7);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(press_done), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        dones = 0; viol = 0;
        repeat (80) begin
            @(negedge clk);
            dones += int'(press_done);
            viol  += int'(busy);
        end
        check("abort_no_done", dones, 0);
        check("abort_stays_idle", viol, 0);

        // Second command held valid through a press
        column = 3'b101;
        kif.cmd_key = 4'd1; kif.cmd_hold = 8'd1; kif.cmd_valid = 1'b1;
        @(negedge clk);
        kif.cmd_key = 4'd2;
        cyc = 0; viol = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (busy && kif.cmd_ready) viol++;
            if (!busy && !press_done) viol++;
        end while (!press_done && cyc < 300);
        check("b2b_no_early_accept", viol, 0);
        check_range("b2b_first_dur", cyc - 1, 44, 48);
        check("b2b_busy_at_done", int'(busy), 0);
        check("b2b_ready_at_done", int'(kif.cmd_ready), 1);
        @(negedge clk);
        check("b2b_second_accept", int'(busy), 1);
        kif.cmd_valid = 1'b0;
        cyc = 0;
        while (!press_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("b2b_second_done", int'(press_done), 1);
        viol = 0;
        repeat (60) begin
            @(negedge clk);
            viol += int'(busy);
        end
        check("b2b_not_queued", viol, 0);

`ifdef KEYPAD_EMULATOR_BOUNCE_EN
        // Chatter in BOUNCE_IN follows the reference LFSR, HOLD is steady closed
        @(negedge clk);
        column = 3'b101; kif.cmd_key = 4'd4; kif.cmd_hold = 8'd10; kif.cmd_valid = 1'b1;
        @(negedge clk);
        kif.cmd_valid = 1'b0;
        bad = 0; low = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (c <= 16 && row != (m_lfsr_d1[0] ? 3'b101 : 3'b111)) bad++;
            if (c >= 22 && row != 3'b101) low++;
        end
        check("bounce_lfsr_pattern", bad, 0);
        check("bounce_hold_steady", low, 0);
        cyc = 0;
        while (!press_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("bounce_done", int'(press_done), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
